// File: rtl/cmul_pipe.sv
// Pipelined small-constant multiplier: k*din per limb in redundant form (no inter-limb carry),
// with a collapsing-bubble valid/ready pipeline, sideband tag and occupancy count.
module cmul_pipe #(
  parameter int unsigned DIN_W   = 288,
  parameter int unsigned N_LIMB  = 4,
  parameter int unsigned LIMB_W  = 72,
  parameter int unsigned MODE_W  = 3,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [MODE_W-1:0]                   mode,
  input  logic [DIN_W-1:0]                    din,
  input  logic [TAG_W-1:0]                    tag_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N_LIMB*(LIMB_W+MODE_W)-1:0]   dout,
  output logic [TAG_W-1:0]                    tag_out,
  output logic [3:0]                          occupancy
);

  localparam int unsigned CW = LIMB_W + MODE_W;
  localparam int unsigned DW = N_LIMB * CW;

  logic [LATENCY-1:0] stage_valid;
  logic [LATENCY-1:0] advance;
  logic [LATENCY-1:0] space;
  logic [DW-1:0]      stage_data [LATENCY];
  logic [TAG_W-1:0]   stage_tag  [LATENCY];
  logic [DW-1:0]      prod;
  logic [3:0]         count;

  always_comb begin
    prod = '0;
    for (int unsigned i = 0; i < N_LIMB; i++) begin
      prod[i*CW +: CW] = CW'(mode) * CW'(din[i*LIMB_W +: LIMB_W]);
    end
  end

  // Ready ripples back from out_ready: a stage has room if empty or if its
  // occupant moves on this cycle, which lets bubbles collapse behind a stall.
  always_comb begin : ready_chain
    logic room;
    advance = '0;
    space   = '0;
    room    = out_ready;
    for (int unsigned n = 0; n < LATENCY; n++) begin
      advance[LATENCY-1-n] = stage_valid[LATENCY-1-n] & room;
      room                 = ~stage_valid[LATENCY-1-n] | advance[LATENCY-1-n];
      space[LATENCY-1-n]   = room;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
      for (int unsigned j = 0; j < LATENCY; j++) begin
        stage_data[j] <= '0;
        stage_tag[j]  <= '0;
      end
    end else begin
      if (space[0]) begin
        stage_valid[0] <= in_valid;
        if (in_valid) begin
          stage_data[0] <= prod;
          stage_tag[0]  <= tag_in;
        end
      end
      // Payload only moves with a valid beat so an emptied stage keeps its last value.
      for (int unsigned j = 1; j < LATENCY; j++) begin
        if (space[j]) begin
          stage_valid[j] <= stage_valid[j-1];
          if (stage_valid[j-1]) begin
            stage_data[j] <= stage_data[j-1];
            stage_tag[j]  <= stage_tag[j-1];
          end
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int unsigned j = 0; j < LATENCY; j++) begin
      count = count + 4'(stage_valid[j]);
    end
  end

  assign in_ready  = space[0];
  assign out_valid = stage_valid[LATENCY-1];
  assign dout      = stage_data[LATENCY-1];
  assign tag_out   = stage_tag[LATENCY-1];
  assign occupancy = count;

endmodule

// File: tb/tb_cmul_pipe.sv
// Directed self-checking bench for cmul_pipe (LATENCY=2): arithmetic corners, latency,
// streaming throughput, backpressure, and asynchronous reset mid-stream.
module tb_cmul_pipe;

  localparam int unsigned CW = 75;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   mode = '0;
  logic [287:0] din = '0;
  logic [7:0]   tag_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [299:0] dout;
  logic [7:0]   tag_out;
  logic [3:0]   occupancy;

  int checks = 0;
  int errors = 0;

  logic [287:0] x_op;
  logic [287:0] y_op;
  logic [299:0] dout_held;

  cmul_pipe #(
    .DIN_W(288), .N_LIMB(4), .LIMB_W(72), .MODE_W(3), .LATENCY(2), .TAG_W(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .din(din), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .tag_out(tag_out), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [299:0] to_int(input logic [299:0] d);
    logic [299:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + ({225'b0, d[i*CW +: CW]} << (i*72));
    end
    return acc;
  endfunction

  task automatic chk(input string name, input logic [299:0] obs, input logic [299:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] m, input logic [287:0] d, input logic [7:0] t);
    in_valid = 1'b1;
    mode     = m;
    din      = d;
    tag_in   = t;
  endtask

  initial begin
    x_op = {72'h00_0000_0000_0000_0001, 72'h80_0000_0000_0000_0000,
            72'h12_3456_789A_BCDE_F012, 72'hFF_FFFF_FFFF_FFFF_FFFE};
    y_op = (288'd1 << 200) | 288'hDEAD_BEEF;

    // Reset state while rst is held
    #1;
    chk("rst_out_valid", {299'b0, out_valid}, 300'd0);
    chk("rst_in_ready", {299'b0, in_ready}, 300'd1);
    chk("rst_occupancy", {296'b0, occupancy}, 300'd0);
    chk("rst_dout", dout, 300'd0);
    chk("rst_tag_out", {292'b0, tag_out}, 300'd0);
    #2 rst = 1'b0;

    // All-ones operand, k=7: latency 2, single-cycle presentation
    beat(3'd7, '1, 8'hA5);
    #1 chk("a_in_ready", {299'b0, in_ready}, 300'd1);
    step;
    in_valid = 1'b0;
    chk("a_occ_after_accept", {296'b0, occupancy}, 300'd1);
    chk("a_not_yet_valid", {299'b0, out_valid}, 300'd0);
    step;
    chk("a_out_valid", {299'b0, out_valid}, 300'd1);
    chk("a_dout_limbs", dout, {4{75'h6_FFFF_FFFF_FFFF_FFFF_F9}});
    chk("a_dout_int", to_int(dout), (300'd7 << 288) - 300'd7);
    chk("a_tag", {292'b0, tag_out}, 300'hA5);
    step;
    chk("a_one_cycle_only", {299'b0, out_valid}, 300'd0);
    chk("a_occ_drained", {296'b0, occupancy}, 300'd0);

    // Streaming three back-to-back beats: k=0, k=1, k=5
    beat(3'd0, '1, 8'h01);
    step;
    beat(3'd1, x_op, 8'h02);
    step;
    chk("b_out_valid", {299'b0, out_valid}, 300'd1);
    chk("b_dout_zero", dout, 300'd0);
    chk("b_tag", {292'b0, tag_out}, 300'h01);
    chk("b_occ_full_stream", {296'b0, occupancy}, 300'd2);
    chk("b_in_ready_stream", {299'b0, in_ready}, 300'd1);
    beat(3'd5, y_op, 8'h03);
    step;
    chk("c_out_valid", {299'b0, out_valid}, 300'd1);
    chk("c_dout_zext", dout, {3'b0, x_op[287:216], 3'b0, x_op[215:144],
                              3'b0, x_op[143:72], 3'b0, x_op[71:0]});
    chk("c_tag", {292'b0, tag_out}, 300'h02);
    in_valid = 1'b0;
    step;
    chk("d_out_valid", {299'b0, out_valid}, 300'd1);
    chk("d_dout_int", to_int(dout), (300'd5 << 200) + 300'h4_5964_BAAB);
    chk("d_tag", {292'b0, tag_out}, 300'h03);
    step;
    chk("d_drained", {299'b0, out_valid}, 300'd0);

    // Backpressure: two accepts fill the pipe, third beat is refused
    out_ready = 1'b0;
    beat(3'd3, 288'h100, 8'h10);
    #1 chk("e_in_ready", {299'b0, in_ready}, 300'd1);
    step;
    beat(3'd2, 288'h5, 8'h11);
    #1 chk("f_in_ready", {299'b0, in_ready}, 300'd1);
    step;
    beat(3'd6, 288'h7, 8'h12);
    #1;
    chk("g_in_ready_full", {299'b0, in_ready}, 300'd0);
    chk("g_occ_full", {296'b0, occupancy}, 300'd2);
    chk("e_dout_held", dout, 300'h300);
    dout_held = dout;
    step;
    chk("g_still_blocked", {299'b0, in_ready}, 300'd0);
    chk("e_dout_stable", dout, dout_held);
    chk("e_tag_stable", {292'b0, tag_out}, 300'h10);
    out_ready = 1'b1;
    #1 chk("g_in_ready_shift", {299'b0, in_ready}, 300'd1);
    step;
    in_valid = 1'b0;
    chk("shift_occ", {296'b0, occupancy}, 300'd2);
    chk("f_dout", dout, 300'hA);
    chk("f_tag", {292'b0, tag_out}, 300'h11);
    step;
    chk("g_dout", dout, 300'h2A);
    chk("g_tag", {292'b0, tag_out}, 300'h12);
    chk("g_occ", {296'b0, occupancy}, 300'd1);
    step;
    chk("bp_drained", {296'b0, occupancy}, 300'd0);

    // Asynchronous reset with two beats in flight
    out_ready = 1'b0;
    beat(3'd7, 288'h1234, 8'h21);
    step;
    beat(3'd7, 288'h5678, 8'h22);
    step;
    in_valid = 1'b0;
    chk("h_occ_before_rst", {296'b0, occupancy}, 300'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", {299'b0, out_valid}, 300'd0);
    chk("ar_occupancy", {296'b0, occupancy}, 300'd0);
    chk("ar_dout", dout, 300'd0);
    chk("ar_tag", {292'b0, tag_out}, 300'd0);
    chk("ar_in_ready", {299'b0, in_ready}, 300'd1);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    beat(3'd4, 288'hFF, 8'h33);
    step;
    in_valid = 1'b0;
    chk("j_not_stale", {299'b0, out_valid}, 300'd0);
    step;
    chk("j_out_valid", {299'b0, out_valid}, 300'd1);
    chk("j_dout", dout, 300'h3FC);
    chk("j_tag", {292'b0, tag_out}, 300'h33);
    step;
    chk("j_no_extra", {299'b0, out_valid}, 300'd0);
    chk("j_occ_end", {296'b0, occupancy}, 300'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
